fu_dpi_pipe: RTL and testbench
==============================

Name: fu_dpi_pipe

Overview:
Parametrised, pipelined data-processing-immediate functional unit for the out-of-order core. It executes MOVZ, MOVN and MOVK with 32- or 64-bit width, ADR, ADRP, and ADD/ADDS/SUB/SUBS immediate, including NZCV generation. It sits between the issue queue and the common data bus. Both ends use valid/ready handshakes, and the unit supports full backpressure and flush.

Parameters:
STAGES, 2, number of result register stages (legal range 1..4); this is also the latency and the in-flight capacity.
PRN_W, 7, physical register number width.
ID_W, 6, instruction id width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  squash all in-flight ops (synchronous)
in_valid  in  1  issue valid
in_ready  out  1  unit can accept this cycle (combinational)
in_inst  in  32  instruction word
in_op_a  in  64  Rn value; for MOVK, the old Rd value
in_pc  in  64  instruction PC
in_prn  in  PRN_W  destination PRN
in_inst_id  in  ID_W  instruction id
out_valid  out  1  result valid
out_ready  in  1  CDB accepts result
out_data0  out  64  Rd result
out_data2  out  64  flags word {60'b0,N,Z,C,V}
out_data_valid  out  3  [0]=Rd written, [1]=always 0, [2]=flags written
out_prn  out  PRN_W  destination PRN
out_inst_id  out  ID_W  instruction id

Behaviour:
- Reset: every stage valid bit is 0, so out_valid=0. All output data, PRN and id registers are 0. in_ready=1 after reset.
- Decode and compute happen combinationally at entry. The result then moves through the STAGES registers; the last stage drives the out_* ports.
- Stage k advances when it is empty or when stage k+1 advances. The last stage advances when out_ready=1 or it is empty.
- in_ready = stage0 empty OR stage0 advancing.
- Accept = in_valid & in_ready & !flush.
- Latency: STAGES cycles with out_ready held at 1. Throughput is 1 op/cycle. Ordering is preserved.
- While out_valid=1 and out_ready=0, all out_* ports hold stable.
- Decode classes (sf = inst[31]):
  - Move wide: inst[28:23]=100101, opc=inst[30:29].
    - opc 00 MOVN: ~(imm16<<16*hw).
    - opc 10 MOVZ: imm16<<16*hw.
    - opc 11 MOVK: in_op_a with halfword hw replaced by imm16.
    - imm16=inst[20:5], hw=inst[22:21].
  - PC-relative: inst[28:24]=10000, imm21 = SignExtend(inst[23:5]:inst[30:29]).
    - ADR (inst[31]=0): pc+imm21.
    - ADRP (inst[31]=1): (pc & ~0xFFF) + (imm21<<12).
  - Add/sub immediate: inst[28:23]=100010.
    - op=inst[30] (1 = subtract), S=inst[29].
    - imm = imm12 (inst[21:10]), shifted left by 12 if inst[22]=1.
    - Result = in_op_a ± imm. Subtract is computed as a + ~imm + 1.
- Width rules: for sf=0, the operation is done on bits [31:0] and the result is zero-extended to 64 bits. N, Z, C and V are taken from the 32-bit operation.
- Move wide with sf=0 and hw[1]=1 is illegal.
- out_data_valid[0]=1 for all legal ops except S=1 with Rd (inst[4:0]) = 31 (CMP/CMN), where it is 0.
- out_data_valid[2]=1 only when S=1. Otherwise out_data2 = 0.
- Flags:
  - N = result MSB.
  - Z = (result == 0).
  - C = carry out; for subtract this is NOT borrow.
  - V = signed overflow.
- Illegal or undecoded instruction: the op is still accepted and emitted with out_valid=1 and out_data_valid=3'b000, so the ROB can retire or trap it.
- Flush: all stage valid bits clear on the next edge and out_valid=0 the following cycle. Nothing in flight is emitted. An op presented in the same cycle as flush is dropped.
- Reset mid-operation: all in-flight ops are discarded immediately (asynchronous reset).

Optional Feature:
FU_DPI_PIPE_ILLEGAL_EN
- Defined: adds output port out_illegal (1 bit), pipelined alongside the data. It is 1 for undecoded encodings and for move wide with sf=0 and hw[1]=1. Reset value 0.
- Undefined: the port does not exist. Illegal ops are identifiable only by out_data_valid=000.

Test Plan:
- MOVK X, imm16=0xABCD, hw=2, op_a=0x1111_2222_3333_4444 -> out_data0=0x1111_ABCD_3333_4444, data_valid=001, after exactly STAGES cycles.
- MOVN W, imm16=0, hw=0 -> out_data0=0x0000_0000_FFFF_FFFF. MOVZ W with hw=2 -> data_valid=000 (and out_illegal=1 when enabled).
- ADRP pc=0x4000_1234, imm21=1 -> out_data0=0x4000_2000. ADR pc=0x1000, imm21=-4 -> out_data0=0xFFC.
- SUBS X, op_a=1, imm=1, Rd=5 -> out_data0=0, NZCV=0110, data_valid=101. Same op with Rd=31 -> data_valid=100. ADDS W, op_a=0x7FFF_FFFF, imm=1 -> out_data0=0x8000_0000, NZCV=1001.
- STAGES=2, out_ready=0, 4 back-to-back issues -> 2 accepted, then in_ready=0. After out_ready=1, results emerge in order one per cycle, and the remaining 2 ops are accepted as the pipeline drains.
- 2 ops in flight, flush asserted with in_valid=1 -> no out_valid for any of the 3 ops. The next op issued after flush emerges normally after STAGES cycles.

Source files
------------

// File: rtl/fu_dpi_pipe.sv
// fu_dpi_pipe: pipelined data-processing-immediate functional unit.
// Executes MOVN/MOVZ/MOVK, ADR/ADRP and ADD/ADDS/SUB/SUBS immediate.
// Latency and in-flight capacity are both STAGES.
// Optional feature macro: FU_DPI_PIPE_ILLEGAL_EN adds the out_illegal port.

package fu_dpi_pipe_pkg;

   // Per-op result payload carried down the pipeline
   typedef struct packed {
      logic [63:0] data0;
      logic [3:0]  nzcv;
      logic [2:0]  dv;
   } res_t;

endpackage

module fu_dpi_pipe
   import fu_dpi_pipe_pkg::*;
#(
   parameter int unsigned STAGES = 2,
   parameter int unsigned PRN_W  = 7,
   parameter int unsigned ID_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [63:0]      in_op_a,
   input  logic [63:0]      in_pc,
   input  logic [PRN_W-1:0] in_prn,
   input  logic [ID_W-1:0]  in_inst_id,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data0,
   output logic [63:0]      out_data2,
   output logic [2:0]       out_data_valid,
   output logic [PRN_W-1:0] out_prn,
   output logic [ID_W-1:0]  out_inst_id
`ifdef FU_DPI_PIPE_ILLEGAL_EN
   ,
   output logic             out_illegal
`endif
);

   localparam int unsigned LAST = STAGES - 1;

   logic              sf;
   logic [5:0]        mw_shift;
   logic [63:0]       mw_imm;
   logic [63:0]       mw_mask;
   logic [63:0]       mw_val;
   logic [63:0]       pr_off;
   logic [63:0]       as_imm;
   logic [63:0]       as_b;
   logic [64:0]       sum64;
   logic [32:0]       sum32;
   logic              as_n;
   logic              as_z;
   logic              as_c;
   logic              as_v;
   res_t              ent;
   logic              accept;

   logic [STAGES-1:0] stg_valid;
   logic [STAGES-1:0] adv;
   res_t              stg_res [STAGES];
   logic [PRN_W-1:0]  stg_prn [STAGES];
   logic [ID_W-1:0]   stg_id  [STAGES];

   // Shared operand preparation for the three instruction classes
   assign sf       = in_inst[31];
   assign mw_shift = {in_inst[22:21], 4'b0000};
   assign mw_imm   = 64'(in_inst[20:5]) << mw_shift;
   assign mw_mask  = 64'h0000_0000_0000_FFFF << mw_shift;
   assign pr_off   = 64'($signed({in_inst[23:5], in_inst[30:29]}));
   assign as_imm   = in_inst[22] ? {40'd0, in_inst[21:10], 12'd0} : {52'd0, in_inst[21:10]};
   assign as_b     = in_inst[30] ? ~as_imm : as_imm;
   assign sum64    = {1'b0, in_op_a} + {1'b0, as_b} + 65'(in_inst[30]);
   assign sum32    = {1'b0, in_op_a[31:0]} + {1'b0, as_b[31:0]} + 33'(in_inst[30]);

   // Flags come from the 32-bit adder when sf=0; C is carry-out (not borrow)
   assign as_n = sf ? sum64[63] : sum32[31];
   assign as_z = sf ? (sum64[63:0] == 64'd0) : (sum32[31:0] == 32'd0);
   assign as_c = sf ? sum64[64] : sum32[32];
   assign as_v = sf ? ((in_op_a[63] == as_b[63]) && (sum64[63] != in_op_a[63]))
                    : ((in_op_a[31] == as_b[31]) && (sum32[31] != in_op_a[31]));

   // Move-wide value selection by opc
   always_comb begin
      mw_val = '0;
      case (in_inst[30:29])
         2'b00:   mw_val = ~mw_imm;
         2'b10:   mw_val = mw_imm;
         default: mw_val = (in_op_a & ~mw_mask) | mw_imm;
      endcase
   end

   // Decode and result formation at entry; anything unrecognised leaves ent zero
   always_comb begin
      ent = '0;
      if (in_inst[28:23] == 6'b100101) begin
         if ((in_inst[30:29] != 2'b01) && !(!sf && in_inst[22])) begin
            ent.data0 = sf ? mw_val : {32'd0, mw_val[31:0]};
            ent.dv    = 3'b001;
         end
      end else if (in_inst[28:24] == 5'b10000) begin
         ent.data0 = sf ? ({in_pc[63:12], 12'd0} + (pr_off << 12)) : (in_pc + pr_off);
         ent.dv    = 3'b001;
      end else if (in_inst[28:23] == 6'b100010) begin
         ent.data0 = sf ? sum64[63:0] : {32'd0, sum32[31:0]};
         ent.nzcv  = in_inst[29] ? {as_n, as_z, as_c, as_v} : 4'd0;
         ent.dv    = {in_inst[29], 1'b0, !(in_inst[29] && (in_inst[4:0] == 5'd31))};
      end
   end

   // Advance chain: a stage moves when it is empty or its successor moves
   always_comb begin
      adv       = '0;
      adv[LAST] = !stg_valid[LAST] || out_ready;
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         adv[k] = !stg_valid[k] || adv[k+1];
      end
   end

   assign in_ready = adv[0];
   assign accept   = in_valid && in_ready && !flush;

   // Pipeline registers; flush kills valids only, payload is don't-care when invalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_valid <= '0;
         for (int k = 0; k < int'(STAGES); k++) begin
            stg_res[k] <= '0;
            stg_prn[k] <= '0;
            stg_id[k]  <= '0;
         end
      end else begin
         if (flush) begin
            stg_valid <= '0;
         end else begin
            if (adv[0]) begin
               stg_valid[0] <= accept;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
               if (adv[k]) begin
                  stg_valid[k] <= stg_valid[k-1];
               end
            end
         end
         if (accept) begin
            stg_res[0] <= ent;
            stg_prn[0] <= in_prn;
            stg_id[0]  <= in_inst_id;
         end
         for (int k = 1; k < int'(STAGES); k++) begin
            if (adv[k] && stg_valid[k-1]) begin
               stg_res[k] <= stg_res[k-1];
               stg_prn[k] <= stg_prn[k-1];
               stg_id[k]  <= stg_id[k-1];
            end
         end
      end
   end

`ifdef FU_DPI_PIPE_ILLEGAL_EN
   logic ent_illegal;
   logic stg_ill [STAGES];

   // Every legal op writes Rd or flags, so an empty write mask marks an illegal op
   assign ent_illegal = (ent.dv == 3'b000);

   // Illegal flag travels alongside the payload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            stg_ill[k] <= 1'b0;
         end
      end else begin
         if (accept) begin
            stg_ill[0] <= ent_illegal;
         end
         for (int k = 1; k < int'(STAGES); k++) begin
            if (adv[k] && stg_valid[k-1]) begin
               stg_ill[k] <= stg_ill[k-1];
            end
         end
      end
   end

   assign out_illegal = stg_ill[LAST];
`endif

   assign out_valid      = stg_valid[LAST];
   assign out_data0      = stg_res[LAST].data0;
   assign out_data2      = {60'd0, stg_res[LAST].nzcv};
   assign out_data_valid = stg_res[LAST].dv;
   assign out_prn        = stg_prn[LAST];
   assign out_inst_id    = stg_id[LAST];

endmodule

// File: tb/tb_fu_dpi_pipe.sv
// Self-checking bench for fu_dpi_pipe: directed plan cases, backpressure,
// flush, mid-run reset and a randomized phase against a reference model.

module tb_fu_dpi_pipe;

   localparam int unsigned STAGES = 2;
   localparam int unsigned PRN_W  = 7;
   localparam int unsigned ID_W   = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_inst = '0;
   logic [63:0]      in_op_a = '0;
   logic [63:0]      in_pc = '0;
   logic [PRN_W-1:0] in_prn = '0;
   logic [ID_W-1:0]  in_inst_id = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [63:0]      out_data0;
   logic [63:0]      out_data2;
   logic [2:0]       out_data_valid;
   logic [PRN_W-1:0] out_prn;
   logic [ID_W-1:0]  out_inst_id;
`ifdef FU_DPI_PIPE_ILLEGAL_EN
   logic             out_illegal;
`endif

   fu_dpi_pipe #(.STAGES(STAGES), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_op_a(in_op_a), .in_pc(in_pc), .in_prn(in_prn), .in_inst_id(in_inst_id),
      .out_valid(out_valid), .out_ready(out_ready), .out_data0(out_data0),
      .out_data2(out_data2), .out_data_valid(out_data_valid),
      .out_prn(out_prn), .out_inst_id(out_inst_id)
`ifdef FU_DPI_PIPE_ILLEGAL_EN
      , .out_illegal(out_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]      d0;
      logic [63:0]      d2;
      logic [2:0]       dv;
      logic             ill;
      logic [PRN_W-1:0] prn;
      logic [ID_W-1:0]  id;
      int               acc;
      bit               lat;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, req, $time);
      end
   endtask

   // Architectural reference: plain arithmetic on the instruction fields
   function automatic exp_t model(input logic [31:0] inst, input logic [63:0] a, input logic [63:0] pc);
      exp_t e;
      logic sf, c, v, n, z, s;
      logic [63:0] r, aw, imm;
      logic signed [20:0] i21;
      logic signed [63:0] off;
      logic signed [65:0] sa, ex;
      int unsigned sh;
      e.d0 = '0; e.d2 = '0; e.dv = '0; e.ill = 1'b0;
      e.prn = '0; e.id = '0; e.acc = 0; e.lat = 1'b0;
      sf = inst[31];
      if (inst[28:23] == 6'b100101) begin
         sh = 16 * int'(inst[22:21]);
         if (inst[30:29] == 2'b01 || (!sf && inst[22])) begin
            e.ill = 1'b1;
         end else begin
            r = 64'(inst[20:5]) << sh;
            if (inst[30:29] == 2'b00) r = ~r;
            else if (inst[30:29] == 2'b11) begin
               r = a;
               r[sh +: 16] = inst[20:5];
            end
            if (!sf) r[63:32] = '0;
            e.d0 = r; e.dv = 3'b001;
         end
      end else if (inst[28:24] == 5'b10000) begin
         i21 = {inst[23:5], inst[30:29]};
         off = i21;
         if (sf) e.d0 = {pc[63:12], 12'h000} + 64'(off * 4096);
         else    e.d0 = pc + 64'(off);
         e.dv = 3'b001;
      end else if (inst[28:23] == 6'b100010) begin
         imm = 64'(inst[21:10]);
         if (inst[22]) imm = imm * 4096;
         s  = inst[29];
         aw = sf ? a : {32'd0, a[31:0]};
         if (inst[30]) begin
            r = aw - imm;
            c = (aw >= imm);
         end else begin
            r = aw + imm;
            c = sf ? (r < aw) : r[32];
         end
         if (!sf) r[63:32] = '0;
         sa = sf ? 66'($signed(a)) : 66'($signed(a[31:0]));
         ex = inst[30] ? sa - $signed({2'b00, imm}) : sa + $signed({2'b00, imm});
         v  = sf ? (ex != 66'($signed(ex[63:0]))) : (ex != 66'($signed(ex[31:0])));
         n  = sf ? r[63] : r[31];
         z  = (r == 64'd0);
         e.d0 = r;
         e.dv = {s, 1'b0, !(s && inst[4:0] == 5'd31)};
         e.d2 = s ? {60'd0, n, z, c, v} : 64'd0;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   // One issue cycle: drive at negedge, decide acceptance just before the edge
   task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] a,
                       input logic [63:0] pc, input bit fl, input bit ordy, input bit lat,
                       input bit ovr, input logic [63:0] od0, input logic [63:0] od2,
                       input logic [2:0] odv, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_inst = inst; in_op_a = a; in_pc = pc; flush = fl; out_ready = ordy;
      in_prn = PRN_W'($urandom); in_inst_id = ID_W'($urandom);
      #4;
      acc = in_valid && in_ready && !flush;
      if (acc) begin
         e = model(inst, a, pc);
         if (ovr) begin
            e.d0 = od0; e.d2 = od2; e.dv = odv; e.ill = (odv == 3'b000);
         end
         e.prn = in_prn; e.id = in_inst_id; e.acc = cyc; e.lat = lat;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [4:0]  rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      case ($urandom_range(0, 4))
         0: w = {1'($urandom), 2'($urandom), 6'b100101, 2'($urandom), 16'($urandom), rd};
         1: w = {1'($urandom), 2'($urandom), 5'b10000, 19'($urandom), rd};
         2, 3: w = {1'($urandom), 2'($urandom), 6'b100010, 1'($urandom), 12'($urandom), 5'($urandom), rd};
         default: w = 32'($urandom);
      endcase
      return w;
   endfunction

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return '1;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h0000_0000_7FFF_FFFF;
         4: return 64'h0000_0000_8000_0000;
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Monitor: pops the scoreboard on every handshake and checks stall stability
   logic [63:0]      h_d0, h_d2;
   logic [2:0]       h_dv;
   logic [PRN_W-1:0] h_prn;
   logic [ID_W-1:0]  h_id;
   bit               stall = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            q.delete();
            stall = 1'b0;
            continue;
         end
         if (stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data0", out_data0, h_d0);
            chk("hold_data2", out_data2, h_d2);
            chk("hold_dv", 64'(out_data_valid), 64'(h_dv));
            chk("hold_prn", 64'(out_prn), 64'(h_prn));
            chk("hold_id", 64'(out_inst_id), 64'(h_id));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("data0", out_data0, e.d0);
               chk("data2", out_data2, e.d2);
               chk("data_valid", 64'(out_data_valid), 64'(e.dv));
               chk("prn", 64'(out_prn), 64'(e.prn));
               chk("inst_id", 64'(out_inst_id), 64'(e.id));
`ifdef FU_DPI_PIPE_ILLEGAL_EN
               chk("illegal", 64'(out_illegal), 64'(e.ill));
`endif
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
            end
         end
         stall = out_valid && !out_ready && !flush;
         h_d0 = out_data0; h_d2 = out_data2; h_dv = out_data_valid;
         h_prn = out_prn; h_id = out_inst_id;
         if (flush) q.delete();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] d_inst [8];
   logic [63:0] d_a    [8];
   logic [63:0] d_pc   [8];
   logic [63:0] d_d0   [8];
   logic [63:0] d_d2   [8];
   logic [2:0]  d_dv   [8];

   initial begin
      bit acc;
      int n_acc;
      int j;
      logic [31:0] bp_inst [4];
      logic [63:0] bp_a    [4];

      d_inst = '{ {1'b1, 2'b11, 6'b100101, 2'b10, 16'hABCD, 5'd1},
                  {1'b0, 2'b00, 6'b100101, 2'b00, 16'h0000, 5'd2},
                  {1'b0, 2'b10, 6'b100101, 2'b10, 16'h1234, 5'd3},
                  {1'b1, 2'b01, 5'b10000, 19'd0, 5'd4},
                  {1'b0, 2'b00, 5'b10000, 19'h7FFFF, 5'd5},
                  {1'b1, 1'b1, 1'b1, 6'b100010, 1'b0, 12'd1, 5'd0, 5'd5},
                  {1'b1, 1'b1, 1'b1, 6'b100010, 1'b0, 12'd1, 5'd0, 5'd31},
                  {1'b0, 1'b0, 1'b1, 6'b100010, 1'b0, 12'd1, 5'd0, 5'd3} };
      d_a    = '{ 64'h1111_2222_3333_4444, 64'h0, 64'h0, 64'h0, 64'h0, 64'd1, 64'd1, 64'h7FFF_FFFF };
      d_pc   = '{ 64'h0, 64'h0, 64'h0, 64'h4000_1234, 64'h1000, 64'h0, 64'h0, 64'h0 };
      d_d0   = '{ 64'h1111_ABCD_3333_4444, 64'h0000_0000_FFFF_FFFF, 64'h0, 64'h4000_2000,
                  64'hFFC, 64'h0, 64'h0, 64'h8000_0000 };
      d_d2   = '{ 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h6, 64'h6, 64'h9 };
      d_dv   = '{ 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b101, 3'b100, 3'b101 };

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #4;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_data0", out_data0, 64'd0);
      chk("rst_data2", out_data2, 64'd0);
      chk("rst_dv", 64'(out_data_valid), 64'd0);
      chk("rst_prn_id", 64'({out_prn, out_inst_id}), 64'd0);
`ifdef FU_DPI_PIPE_ILLEGAL_EN
      chk("rst_illegal", 64'(out_illegal), 64'd0);
`endif

      // Directed plan cases, back-to-back with out_ready held high
      for (int i = 0; i < 8; i++) begin
         step(1'b1, d_inst[i], d_a[i], d_pc[i], 1'b0, 1'b1, 1'b1, 1'b1, d_d0[i], d_d2[i], d_dv[i], acc);
         chk("directed_accept", 64'(acc), 64'd1);
      end
      idle(STAGES + 2);

      // Backpressure: only STAGES ops fit while the CDB stalls
      for (int i = 0; i < 4; i++) begin
         bp_inst[i] = {1'($urandom), 2'($urandom), 6'b100010, 1'($urandom), 12'($urandom), 5'd0, 5'd7};
         bp_a[i]    = rand_val();
      end
      n_acc = 0;
      j = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, bp_inst[j], bp_a[j], '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
         if (acc) begin n_acc++; j++; end
      end
      chk("bp_accepted", 64'(n_acc), 64'((STAGES < 4) ? STAGES : 4));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      for (int t = 0; t < 20 && j < 4; t++) begin
         step(1'b1, bp_inst[j], bp_a[j], '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
         if (acc) j++;
      end
      chk("bp_all_accepted", 64'(j), 64'd4);
      idle(STAGES + 2);

      // Flush with two ops held in flight and a third presented alongside
      n_acc = 0;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, d_inst[i], d_a[i], d_pc[i], 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
         if (acc) n_acc++;
      end
      chk("flush_pre_accept", 64'(n_acc), 64'd2);
      step(1'b1, d_inst[5], d_a[5], '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
      for (int i = 0; i < int'(STAGES) + 2; i++) begin
         step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
         chk("flush_quiet", 64'(out_valid), 64'd0);
      end
      step(1'b1, d_inst[7], d_a[7], '0, 1'b0, 1'b1, 1'b1, 1'b1, d_d0[7], d_d2[7], d_dv[7], acc);
      chk("post_flush_accept", 64'(acc), 64'd1);
      idle(STAGES + 2);

      // Asynchronous reset with ops in flight
      for (int i = 0; i < 2; i++)
         step(1'b1, d_inst[i], d_a[i], d_pc[i], 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Randomized traffic with random backpressure and occasional flush
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 9) < 7), rand_inst(), rand_val(), rand_val(),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
              1'b0, 1'b0, '0, '0, '0, acc);
      end

      // Drain and confirm nothing is left owed
      for (int t = 0; t < 50 && q.size() != 0; t++) idle(1);
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
